branch_rs: RTL and testbench

BRANCH_RS -- requirements
Module: branch_rs

---
 rtl/branch_rs.sv | 185 ++++++++++++++++++
 tb/tb_branch_rs.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_rs.sv
// branch_rs: age-ordered reservation station feeding a single branch unit.
// Entries sit in slots 0..count-1 (slot 0 oldest), pick up operands from the
// CDB, and the oldest entry whose operands are both ready is issued into a
// registered output stage, one per cycle.
// Optional feature: define BRA_RS_CDB_BYPASS_EN to let an entry issue in the
// same cycle that its last missing operand is broadcast on the CDB.

`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 4
`endif
`ifndef BEQ
`define BEQ 4'd1
`endif
`ifndef BNE
`define BNE 4'd2
`endif

module branch_rs #(
  parameter int ENTRIES = 4,
  parameter int ROB_W   = `ROB_ENTRY_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         disp_valid,
  output logic                         disp_ready,
  input  logic [3:0]                   disp_op,
  input  logic [31:0]                  disp_pc,
  input  logic [31:0]                  disp_offset,
  input  logic [31:0]                  disp_vj,
  input  logic [31:0]                  disp_vk,
  input  logic                         disp_rj,
  input  logic                         disp_rk,
  input  logic [ROB_W-1:0]             disp_qj,
  input  logic [ROB_W-1:0]             disp_qk,
  input  logic [ROB_W-1:0]             disp_dest,
  input  logic                         cdb_valid,
  input  logic [ROB_W-1:0]             cdb_tag,
  input  logic [31:0]                  cdb_value,
  input  logic                         flush,
  output logic [3:0]                   bra_op,
  output logic [31:0]                  bra_srca,
  output logic [31:0]                  bra_srcb,
  output logic [31:0]                  bra_pc,
  output logic [31:0]                  bra_offset,
  output logic [ROB_W-1:0]             bra_dest,
  output logic [$clog2(ENTRIES+1)-1:0] count
);

  localparam int CW = $clog2(ENTRIES + 1);
  localparam int IW = $clog2(ENTRIES);

  typedef struct packed {
    logic [3:0]       op;
    logic [31:0]      pc;
    logic [31:0]      offset;
    logic [31:0]      vj;
    logic [31:0]      vk;
    logic             rj;
    logic             rk;
    logic [ROB_W-1:0] qj;
    logic [ROB_W-1:0] qk;
    logic [ROB_W-1:0] dest;
  } entry_t;

  entry_t           slots      [ENTRIES];
  entry_t           woken      [ENTRIES+1];
  entry_t           next_slots [ENTRIES];
  entry_t           new_entry;
  logic [ENTRIES-1:0] eligible;
  logic             issue_found;
  logic [IW-1:0]    issue_idx;
  logic             accept;
  logic [CW-1:0]    kept_count;
  logic [CW-1:0]    next_count;

  assign disp_ready = (int'(count) < ENTRIES) && !flush;
  assign accept     = disp_valid && disp_ready && (disp_op != 4'd0);

  // Stored entries as they look after this edge's CDB capture; the extra
  // all-zero slot on top lets compaction shift in from above without bounds checks.
  always_comb begin
    for (int i = 0; i <= ENTRIES; i++) woken[i] = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      woken[i] = slots[i];
      if (cdb_valid && !slots[i].rj && (slots[i].qj == cdb_tag)) begin
        woken[i].vj = cdb_value;
        woken[i].rj = 1'b1;
      end
      if (cdb_valid && !slots[i].rk && (slots[i].qk == cdb_tag)) begin
        woken[i].vk = cdb_value;
        woken[i].rk = 1'b1;
      end
    end
  end

  // Eligibility and oldest-first pick; the bypass build counts a same-cycle
  // CDB match as ready, the default build only trusts the stored ready bits.
  always_comb begin
    eligible    = '0;
    issue_found = 1'b0;
    issue_idx   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
`ifdef BRA_RS_CDB_BYPASS_EN
      eligible[i] = (i < int'(count)) && woken[i].rj && woken[i].rk;
`else
      eligible[i] = (i < int'(count)) && slots[i].rj && slots[i].rk;
`endif
    end
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        issue_found = 1'b1;
        issue_idx   = IW'(i);
      end
    end
  end

  // Incoming dispatch, grabbing any operand broadcast on the CDB this same cycle.
  always_comb begin
    new_entry        = '0;
    new_entry.op     = disp_op;
    new_entry.pc     = disp_pc;
    new_entry.offset = disp_offset;
    new_entry.vj     = disp_vj;
    new_entry.vk     = disp_vk;
    new_entry.rj     = disp_rj;
    new_entry.rk     = disp_rk;
    new_entry.qj     = disp_qj;
    new_entry.qk     = disp_qk;
    new_entry.dest   = disp_dest;
    if (!disp_rj && cdb_valid && (disp_qj == cdb_tag)) begin
      new_entry.vj = cdb_value;
      new_entry.rj = 1'b1;
    end
    if (!disp_rk && cdb_valid && (disp_qk == cdb_tag)) begin
      new_entry.vk = cdb_value;
      new_entry.rk = 1'b1;
    end
  end

  // Remove the issued entry, close the gap, then append the dispatch at the tail.
  always_comb begin
    kept_count = issue_found ? (count - CW'(1)) : count;
    next_count = accept ? (kept_count + CW'(1)) : kept_count;
    for (int i = 0; i < ENTRIES; i++) begin
      next_slots[i] = woken[i];
      if (issue_found && (i >= int'(issue_idx))) next_slots[i] = woken[i+1];
      if (accept && (i == int'(kept_count))) next_slots[i] = new_entry;
    end
  end

  // Entry storage and occupancy; flush empties the station outright.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      for (int i = 0; i < ENTRIES; i++) slots[i] <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      count <= next_count;
      for (int i = 0; i < ENTRIES; i++) slots[i] <= next_slots[i];
    end
  end

  // Output stage to the branch unit; operands hold when nothing issues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bra_op     <= 4'd0;
      bra_srca   <= '0;
      bra_srcb   <= '0;
      bra_pc     <= '0;
      bra_offset <= '0;
      bra_dest   <= '0;
    end else if (flush || !issue_found) begin
      bra_op <= 4'd0;
    end else begin
      bra_op     <= woken[issue_idx].op;
      bra_srca   <= woken[issue_idx].vj;
      bra_srcb   <= woken[issue_idx].vk;
      bra_pc     <= woken[issue_idx].pc;
      bra_offset <= woken[issue_idx].offset;
      bra_dest   <= woken[issue_idx].dest;
    end
  end

endmodule

// File: tb/tb_branch_rs.sv
// tb_branch_rs: directed scenarios plus random traffic for branch_rs, checked
// against a queue-based reference model through a per-edge scoreboard.

`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 4
`endif
`ifndef BEQ
`define BEQ 4'd1
`endif
`ifndef BNE
`define BNE 4'd2
`endif

module tb_branch_rs;

  localparam int ENTRIES = 4;
  localparam int ROB_W   = `ROB_ENTRY_WIDTH;
  localparam int CW      = $clog2(ENTRIES + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             disp_valid = 1'b0;
  logic             disp_ready;
  logic [3:0]       disp_op = '0;
  logic [31:0]      disp_pc = '0, disp_offset = '0, disp_vj = '0, disp_vk = '0;
  logic             disp_rj = 1'b0, disp_rk = 1'b0;
  logic [ROB_W-1:0] disp_qj = '0, disp_qk = '0, disp_dest = '0;
  logic             cdb_valid = 1'b0;
  logic [ROB_W-1:0] cdb_tag = '0;
  logic [31:0]      cdb_value = '0;
  logic             flush = 1'b0;
  logic [3:0]       bra_op;
  logic [31:0]      bra_srca, bra_srcb, bra_pc, bra_offset;
  logic [ROB_W-1:0] bra_dest;
  logic [CW-1:0]    count;

  branch_rs #(.ENTRIES(ENTRIES), .ROB_W(ROB_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_pc(disp_pc), .disp_offset(disp_offset),
    .disp_vj(disp_vj), .disp_vk(disp_vk), .disp_rj(disp_rj), .disp_rk(disp_rk),
    .disp_qj(disp_qj), .disp_qk(disp_qk), .disp_dest(disp_dest),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .flush(flush),
    .bra_op(bra_op), .bra_srca(bra_srca), .bra_srcb(bra_srcb),
    .bra_pc(bra_pc), .bra_offset(bra_offset), .bra_dest(bra_dest),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic v; logic [3:0] op; logic [31:0] pc, off, vj, vk; logic rj, rk;
    logic [ROB_W-1:0] qj, qk, dest; logic cv; logic [ROB_W-1:0] ct;
    logic [31:0] cval; logic fl;
  } stim_t;

  typedef struct {
    logic [3:0] op; logic [31:0] pc, off, vj, vk; logic rj, rk;
    logic [ROB_W-1:0] qj, qk, dest;
  } m_ent_t;

  typedef struct {
    logic [3:0] op; logic [31:0] srca, srcb, pc, off; logic [ROB_W-1:0] dest; int cnt;
  } exp_t;

  m_ent_t rs[$];
  exp_t   exp_q[$];
  exp_t   last;
  exp_t   mon_e;
  int     tests_run = 0;
  int     tests_failed = 0;

  task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] expv);
    tests_run++;
    if (act !== expv) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic stim_t mkDisp(input logic [3:0] op, input logic [31:0] pc, off, vj, vk,
                                   input logic rj, rk, input logic [ROB_W-1:0] qj, qk, dest);
    stim_t s = '0;
    s.v = 1'b1; s.op = op; s.pc = pc; s.off = off; s.vj = vj; s.vk = vk;
    s.rj = rj; s.rk = rk; s.qj = qj; s.qk = qk; s.dest = dest;
    return s;
  endfunction

  function automatic stim_t mkCdb(input stim_t base, input logic [ROB_W-1:0] tag, input logic [31:0] val);
    stim_t s = base;
    s.cv = 1'b1; s.ct = tag; s.cval = val;
    return s;
  endfunction

  // Reference model: one clock edge applied to a queue of waiting branches.
  task automatic modelStep();
    int idx;
    int size_before;
    logic rdj, rdk;
    m_ent_t ne;
    exp_t e;
    if (!rst_n) begin
      rs.delete();
      last = '{op: 4'd0, srca: '0, srcb: '0, pc: '0, off: '0, dest: '0, cnt: 0};
    end else if (flush) begin
      rs.delete();
      last.op = 4'd0;
    end else begin
      size_before = rs.size();
      idx = -1;
      foreach (rs[i]) begin
        rdj = rs[i].rj;
        rdk = rs[i].rk;
`ifdef BRA_RS_CDB_BYPASS_EN
        if (cdb_valid && rs[i].qj == cdb_tag) rdj = 1'b1;
        if (cdb_valid && rs[i].qk == cdb_tag) rdk = 1'b1;
`endif
        if (idx < 0 && rdj && rdk) idx = i;
      end
      foreach (rs[i]) begin
        if (cdb_valid && !rs[i].rj && rs[i].qj == cdb_tag) begin rs[i].vj = cdb_value; rs[i].rj = 1'b1; end
        if (cdb_valid && !rs[i].rk && rs[i].qk == cdb_tag) begin rs[i].vk = cdb_value; rs[i].rk = 1'b1; end
      end
      if (idx >= 0) begin
        last.op = rs[idx].op; last.srca = rs[idx].vj; last.srcb = rs[idx].vk;
        last.pc = rs[idx].pc; last.off = rs[idx].off; last.dest = rs[idx].dest;
        rs.delete(idx);
      end else begin
        last.op = 4'd0;
      end
      if (disp_valid && size_before < ENTRIES && disp_op != 4'd0) begin
        ne = '{op: disp_op, pc: disp_pc, off: disp_offset, vj: disp_vj, vk: disp_vk,
               rj: disp_rj, rk: disp_rk, qj: disp_qj, qk: disp_qk, dest: disp_dest};
        if (!ne.rj && cdb_valid && ne.qj == cdb_tag) begin ne.vj = cdb_value; ne.rj = 1'b1; end
        if (!ne.rk && cdb_valid && ne.qk == cdb_tag) begin ne.vk = cdb_value; ne.rk = 1'b1; end
        rs.push_back(ne);
      end
    end
    e = last;
    e.cnt = rs.size();
    exp_q.push_back(e);
  endtask

  task automatic driveInputs(input stim_t s);
    disp_valid = s.v; disp_op = s.op; disp_pc = s.pc; disp_offset = s.off;
    disp_vj = s.vj; disp_vk = s.vk; disp_rj = s.rj; disp_rk = s.rk;
    disp_qj = s.qj; disp_qk = s.qk; disp_dest = s.dest;
    cdb_valid = s.cv; cdb_tag = s.ct; cdb_value = s.cval; flush = s.fl;
  endtask

  // One clock cycle: drive at the falling edge, check disp_ready, model the rising edge.
  task automatic applyStimulus(input stim_t s);
    @(negedge clk);
    driveInputs(s);
    #1;
    checkOutput("disp_ready", 160'(disp_ready), 160'((rs.size() < ENTRIES) && !s.fl));
    @(posedge clk);
    modelStep();
  endtask

  task automatic applyReset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    driveInputs('0);
    #1;
    checkOutput("reset_bra_op", 160'(bra_op), 160'(0));
    checkOutput("reset_payload", 160'({bra_srca, bra_srcb, bra_pc, bra_offset, bra_dest}), 160'(0));
    checkOutput("reset_count", 160'(count), 160'(0));
    @(posedge clk);
    modelStep();
    #2;
    rst_n = 1'b1;
  endtask

  // Monitor: compare every edge's expected outputs, one record per falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        checkOutput("bra_op", 160'(bra_op), 160'(mon_e.op));
        checkOutput("bra_payload", 160'({bra_srca, bra_srcb, bra_pc, bra_offset, bra_dest}),
                    160'({mon_e.srca, mon_e.srcb, mon_e.pc, mon_e.off, mon_e.dest}));
        checkOutput("count", 160'(count), 160'(mon_e.cnt));
      end
    end
  end

  stim_t idle;
  stim_t s;
  int    r;

  initial begin
    idle = '0;
    last = '{op: 4'd0, srca: '0, srcb: '0, pc: '0, off: '0, dest: '0, cnt: 0};
    applyReset();

    // Ready BEQ issues one edge after it is written, then the unit goes idle.
    applyStimulus(mkDisp(`BEQ, 32'h100, 32'h20, 32'd5, 32'd5, 1'b1, 1'b1, '0, '0, ROB_W'(3)));
    applyStimulus(idle);
    applyStimulus(idle);

    // BNE waiting on tag 7 sits until the CDB supplies it.
    applyStimulus(mkDisp(`BNE, 32'h200, 32'h40, 32'd0, 32'd1, 1'b0, 1'b1, ROB_W'(7), '0, ROB_W'(1)));
    repeat (3) applyStimulus(idle);
    applyStimulus(mkCdb(idle, ROB_W'(7), 32'd9));
    repeat (2) applyStimulus(idle);

    // Fill the station, attempt a dropped fifth dispatch, wake only slot 2.
    for (int i = 0; i < 4; i++)
      applyStimulus(mkDisp(`BEQ, 32'h300 + 32'(i * 4), 32'h8, 32'd0, 32'd2, 1'b0, 1'b1,
                           ROB_W'(8 + i), '0, ROB_W'(i)));
    applyStimulus(mkDisp(`BNE, 32'h400, 32'h8, 32'd1, 32'd1, 1'b1, 1'b1, '0, '0, ROB_W'(5)));
    applyStimulus(mkCdb(idle, ROB_W'(10), 32'h77));
    repeat (2) applyStimulus(idle);
    applyStimulus(mkCdb(idle, ROB_W'(8), 32'h11));
    applyStimulus(mkCdb(idle, ROB_W'(9), 32'h22));
    applyStimulus(mkCdb(idle, ROB_W'(11), 32'h33));
    repeat (2) applyStimulus(idle);

    // Oldest and youngest wake on the same edge: oldest issues first.
    applyStimulus(mkDisp(`BEQ, 32'h500, 32'h4, 32'd0, 32'd3, 1'b0, 1'b1, ROB_W'(12), '0, ROB_W'(0)));
    applyStimulus(mkDisp(`BNE, 32'h504, 32'h4, 32'd0, 32'd3, 1'b0, 1'b1, ROB_W'(9), '0, ROB_W'(1)));
    applyStimulus(mkDisp(`BEQ, 32'h508, 32'h4, 32'd0, 32'd3, 1'b0, 1'b1, ROB_W'(10), '0, ROB_W'(2)));
    applyStimulus(mkDisp(`BNE, 32'h50c, 32'h4, 32'd0, 32'd3, 1'b0, 1'b1, ROB_W'(12), '0, ROB_W'(3)));
    applyStimulus(mkCdb(idle, ROB_W'(12), 32'hC0));
    repeat (3) applyStimulus(idle);

    // Flush with three waiting entries and a dispatch in flight; nothing issues afterwards.
    s = idle; s.fl = 1'b1;
    applyStimulus(s);
    for (int i = 0; i < 3; i++)
      applyStimulus(mkDisp(`BEQ, 32'h600 + 32'(i), 32'h4, 32'd0, 32'd0, 1'b0, 1'b0,
                           ROB_W'(1), ROB_W'(2), ROB_W'(i)));
    s = mkDisp(`BEQ, 32'h700, 32'h4, 32'd1, 32'd1, 1'b1, 1'b1, '0, '0, ROB_W'(6));
    s.fl = 1'b1;
    applyStimulus(s);
    applyStimulus(mkCdb(idle, ROB_W'(1), 32'h1));
    applyStimulus(mkCdb(idle, ROB_W'(2), 32'h2));
    applyStimulus(idle);

    // Dispatch catches its own operand from the CDB in the same cycle.
    applyStimulus(mkCdb(mkDisp(`BNE, 32'h800, 32'h10, 32'd0, 32'd4, 1'b0, 1'b1,
                               ROB_W'(5), '0, ROB_W'(2)), ROB_W'(5), 32'hAB));
    repeat (2) applyStimulus(idle);

    // Reset in the middle of work discards pending entries.
    applyStimulus(mkDisp(`BEQ, 32'h900, 32'h4, 32'd0, 32'd1, 1'b0, 1'b1, ROB_W'(4), '0, ROB_W'(4)));
    applyStimulus(mkDisp(`BNE, 32'h904, 32'h4, 32'd2, 32'd1, 1'b1, 1'b1, '0, '0, ROB_W'(5)));
    applyReset();
    applyStimulus(mkCdb(idle, ROB_W'(4), 32'h44));
    applyStimulus(idle);

    // Random traffic with a small tag space so CDB hits are frequent.
    for (int n = 0; n < 600; n++) begin
      s = '0;
      s.v = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 9);
      s.op = (r == 0) ? 4'd0 : ((r < 5) ? `BEQ : `BNE);
      s.pc = $urandom; s.off = $urandom; s.vj = $urandom; s.vk = $urandom;
      s.rj = $urandom_range(0, 1) != 0; s.rk = $urandom_range(0, 1) != 0;
      s.qj = ROB_W'($urandom_range(0, 3)); s.qk = ROB_W'($urandom_range(0, 3));
      s.dest = ROB_W'($urandom);
      s.cv = $urandom_range(0, 1) != 0;
      s.ct = ROB_W'($urandom_range(0, 3));
      s.cval = $urandom;
      s.fl = ($urandom_range(0, 39) == 0);
      applyStimulus(s);
      if (n == 300) applyReset();
    end
    repeat (3) applyStimulus(idle);

    @(negedge clk);
    #1;
    checkOutput("scoreboard_drained", 160'(exp_q.size()), 160'(0));
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
